// File: rtl/qspi_master.sv
// Single/dual/quad SPI master with programmable clock divider, CPOL/CPHA and bit order.
// Every non-idle FSM state lasts dvsr+1 clocks; data moves only on state transitions.
module qspi_master #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] dvsr,
  input  logic          start,
  input  logic          cpol,
  input  logic          cpha,
  input  logic [1:0]    mode,
  input  logic          dir,
  input  logic          msb_first,
  input  logic [3:0]    io_in,
  output logic [3:0]    io_out,
  output logic [3:0]    io_oe,
  output logic          sclk,
  output logic          ss_n,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          done_tick
);

  localparam int unsigned BW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, SETUP, P0, P1} state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_dvsr;
  logic          r_cpol;
  logic          r_cpha;
  logic [1:0]    r_mode;
  logic          r_dir;
  logic          r_msb;
  logic [BW-1:0] r_beat;
  logic [DW-1:0] r_tx;
  logic [DW-1:0] r_rx;
  logic [DW-1:0] r_dout;
  logic [3:0]    r_io_out;
  logic [3:0]    r_io_oe;
  logic          r_sclk;
  logic          r_ss_n;
  logic          r_ready;
  logic          r_done;

  logic          w_tick;
  logic          w_last;
  logic          w_accept;
  logic          w_p0_exit;
  logic          w_p1_exit;
  logic          w_drive;
  logic          w_sample;
  logic          w_done;
  logic          w_cpol_next;
  logic [3:0]    w_rx_bits;
  logic [DW-1:0] w_rx_next;

  function automatic int unsigned f_lanes(input logic [1:0] m);
    case (m)
      2'b01:   f_lanes = 2;
      2'b10:   f_lanes = 4;
      default: f_lanes = 1;
    endcase
  endfunction

  function automatic logic [3:0] f_mask(input logic [1:0] m);
    case (m)
      2'b01:   f_mask = 4'b0011;
      2'b10:   f_mask = 4'b1111;
      default: f_mask = 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] f_oe(input logic [1:0] m, input logic d);
    case (m)
      2'b01:   f_oe = d ? 4'b0000 : 4'b0011;
      2'b10:   f_oe = d ? 4'b0000 : 4'b1111;
      default: f_oe = 4'b0001;
    endcase
  endfunction

  // Next beat to transmit: top L bits (MSB-first) or bottom L bits (LSB-first).
  function automatic logic [3:0] f_beat(input logic [DW-1:0] w, input logic [1:0] m,
                                        input logic msb);
    logic [DW-1:0] s;
    s = msb ? (w >> (DW - f_lanes(m))) : w;
    f_beat = s[3:0] & f_mask(m);
  endfunction

  function automatic logic [DW-1:0] f_shift(input logic [DW-1:0] w, input logic [1:0] m,
                                            input logic msb);
    f_shift = msb ? (w << f_lanes(m)) : (w >> f_lanes(m));
  endfunction

  // Receive mirrors transmit so a lane loopback reproduces the sent word.
  function automatic logic [DW-1:0] f_rx(input logic [DW-1:0] acc, input logic [3:0] bits,
                                         input logic [1:0] m, input logic msb);
    logic [DW-1:0] b;
    b = DW'(bits & f_mask(m));
    if (msb) f_rx = (acc << f_lanes(m)) | b;
    else     f_rx = (acc >> f_lanes(m)) | (b << (DW - f_lanes(m)));
  endfunction

  function automatic logic f_last(input logic [BW-1:0] beat, input logic [1:0] m);
    case (m)
      2'b01:   f_last = (beat == BW'(DW / 2 - 1));
      2'b10:   f_last = (beat == BW'(DW / 4 - 1));
      default: f_last = (beat == BW'(DW - 1));
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tick       = (r_cnt == r_dvsr);
    w_last       = f_last(r_beat, r_mode);
    case (r_state)
      IDLE:    if (start)  w_state_next = SETUP;
      SETUP:   if (w_tick) w_state_next = P0;
      P0:      if (w_tick) w_state_next = P1;
      P1:      if (w_tick) w_state_next = w_last ? IDLE : P0;
      default: w_state_next = IDLE;
    endcase
  end

  // Transfer events; edge roles swap with cpha.
  assign w_accept    = (r_state == IDLE) && start;
  assign w_p0_exit   = (r_state == P0) && w_tick;
  assign w_p1_exit   = (r_state == P1) && w_tick;
  assign w_done      = w_p1_exit && w_last;
  assign w_drive     = r_cpha ? w_p0_exit : (w_p1_exit && !w_last);
  assign w_sample    = r_cpha ? w_p1_exit : w_p0_exit;
  assign w_cpol_next = w_accept ? cpol : r_cpol;
  assign w_rx_bits   = (r_mode == 2'b01 || r_mode == 2'b10) ? io_in : {3'b000, io_in[1]};
  assign w_rx_next   = f_rx(r_rx, w_rx_bits, r_mode, r_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dvsr   <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_mode   <= 2'b00;
      r_dir    <= 1'b0;
      r_msb    <= 1'b0;
      r_beat   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_dout   <= '0;
      r_io_out <= 4'b0000;
      r_io_oe  <= 4'b0000;
      r_sclk   <= 1'b0;
      r_ss_n   <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_sclk  <= (w_state_next == P1) ? ~w_cpol_next : w_cpol_next;
      r_ready <= (w_state_next == IDLE);
      r_done  <= w_done;
      if (r_state == IDLE || w_state_next != r_state) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + CW'(1);

      if (w_accept) begin
        r_dvsr  <= dvsr;
        r_cpol  <= cpol;
        r_cpha  <= cpha;
        r_mode  <= mode;
        r_dir   <= dir;
        r_msb   <= msb_first;
        r_beat  <= '0;
        r_rx    <= '0;
        r_ss_n  <= 1'b0;
        r_io_oe <= f_oe(mode, dir);
        // cpha=0 presents the first beat before the first sclk edge.
        if (cpha) begin
          r_tx     <= din;
          r_io_out <= 4'b0000;
        end else begin
          r_tx     <= f_shift(din, mode, msb_first);
          r_io_out <= f_beat(din, mode, msb_first) & f_oe(mode, dir);
        end
      end else begin
        if (w_drive) begin
          r_io_out <= f_beat(r_tx, r_mode, r_msb) & f_oe(r_mode, r_dir);
          r_tx     <= f_shift(r_tx, r_mode, r_msb);
        end
        if (w_sample)  r_rx   <= w_rx_next;
        if (w_p1_exit) r_beat <= r_beat + BW'(1);
        if (w_done) begin
          r_dout   <= r_cpha ? w_rx_next : r_rx;
          r_ss_n   <= 1'b1;
          r_io_oe  <= 4'b0000;
          r_io_out <= 4'b0000;
        end
      end
    end
  end

  assign io_out    = r_io_out;
  assign io_oe     = r_io_oe;
  assign sclk      = r_sclk;
  assign ss_n      = r_ss_n;
  assign dout      = r_dout;
  assign ready     = r_ready;
  assign done_tick = r_done;

endmodule
